// File: rtl/mccoy_feeder_pkg.sv
// Shared types and defaults for the McCoy program feeder.
// Optional checksum output is enabled by defining MCCOY_FEEDER_CSUM_EN.
package mccoy_feeder_pkg;
  localparam int PC_W = 6;
  localparam int IW   = 6;
  localparam logic [IW-1:0] FILL_WORD = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_RUN,
    S_HALT
  } state_e;
endpackage

// File: rtl/mccoy_prog_feeder_if.sv
// Load stream, run control and core-facing signals of the program feeder.
// csum is present only when MCCOY_FEEDER_CSUM_EN is defined.
interface mccoy_prog_feeder_if #(
  parameter int IW = mccoy_feeder_pkg::IW,
  parameter int CW = 16
);
  logic                                 load_start;
  logic                                 load_valid;
  logic                                 load_last;
  logic [IW-1:0]                        load_data;
  logic                                 load_ready;
  logic                                 run_en;
  logic [mccoy_feeder_pkg::PC_W-1:0]    pc_in;
  logic [IW-1:0]                        instr_out;
  logic                                 core_reset;
  logic                                 halted;
  logic [CW-1:0]                        cycle_count;
`ifdef MCCOY_FEEDER_CSUM_EN
  logic [IW-1:0]                        csum;
`endif

  modport slave (
    input  load_start, load_valid, load_last, load_data, run_en, pc_in,
    output load_ready, instr_out, core_reset, halted, cycle_count
`ifdef MCCOY_FEEDER_CSUM_EN
    , output csum
`endif
  );

  modport master (
    output load_start, load_valid, load_last, load_data, run_en, pc_in,
    input  load_ready, instr_out, core_reset, halted, cycle_count
`ifdef MCCOY_FEEDER_CSUM_EN
    , input csum
`endif
  );
endinterface

// File: rtl/mccoy_prog_mem.sv
// Program store: synchronous write, asynchronous read, contents survive reset.
module mccoy_prog_mem #(
  parameter int DEPTH = 64,
  parameter int IW    = 6,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);
  logic [IW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mccoy_prog_feeder.sv
// Loads a program, holds the McCoy core in reset until a run, serves instr by PC,
// and detects the self-loop halt. Optional checksum: MCCOY_FEEDER_CSUM_EN.
module mccoy_prog_feeder
  import mccoy_feeder_pkg::*;
#(
  parameter int              DEPTH       = 64,
  parameter int              IW          = mccoy_feeder_pkg::IW,
  parameter logic [IW-1:0]   FILL_WORD   = mccoy_feeder_pkg::FILL_WORD,
  parameter int              HALT_REPEAT = 4,
  parameter int              CW          = 16
) (
  input  logic             clk,
  input  logic             reset,
  mccoy_prog_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PC_W:0]     len_q, len_d;
  logic              loaded_q, loaded_d;
  logic              halted_q, halted_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [3:0]        rep_q, rep_d;
  logic [PC_W-1:0]   pc_prev_q, pc_prev_d;
  logic              prev_vld_q, prev_vld_d;
`ifdef MCCOY_FEEDER_CSUM_EN
  logic [IW-1:0]     csum_q, csum_d;
`endif

  logic          accept, running, pc_hit;
  logic [IW-1:0] rdata;

  assign accept  = (state_q == S_LOAD) && bus.load_valid;
  assign running = (state_q == S_RUN) || (state_q == S_HALT);
  assign pc_hit  = {1'b0, bus.pc_in} < len_q;

  mccoy_prog_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.load_data),
    .raddr_i (bus.pc_in[AW-1:0]),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    loaded_d   = loaded_q;
    halted_d   = halted_q;
    cyc_d      = cyc_q;
    rep_d      = rep_q;
    pc_prev_d  = pc_prev_q;
    prev_vld_d = prev_vld_q;
`ifdef MCCOY_FEEDER_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          loaded_d = 1'b0;
`ifdef MCCOY_FEEDER_CSUM_EN
          csum_d   = '0;
`endif
        end else if (loaded_q && bus.run_en) begin
          state_d = S_PRIME;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 6'd1;
`ifdef MCCOY_FEEDER_CSUM_EN
          csum_d   = csum_q ^ bus.load_data;
`endif
          // Last slot closes the load even without load_last, so extra words are refused.
          if (bus.load_last || ({1'b0, wr_ptr_q} == 7'(DEPTH - 1))) begin
            len_d    = {1'b0, wr_ptr_q} + 7'd1;
            loaded_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_PRIME: begin
        cyc_d      = '0;
        halted_d   = 1'b0;
        rep_d      = '0;
        prev_vld_d = 1'b0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CW'(1);
        pc_prev_d  = bus.pc_in;
        prev_vld_d = 1'b1;
        rep_d      = (prev_vld_q && (bus.pc_in == pc_prev_q)) ? rep_q + 4'd1 : 4'd0;
        if (!bus.run_en) begin
          state_d = S_IDLE;
        end else if (rep_d == 4'(HALT_REPEAT - 1)) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end
      end
      S_HALT: begin
        if (!bus.run_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      loaded_q   <= 1'b0;
      halted_q   <= 1'b0;
      cyc_q      <= '0;
      rep_q      <= '0;
      pc_prev_q  <= '0;
      prev_vld_q <= 1'b0;
`ifdef MCCOY_FEEDER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      loaded_q   <= loaded_d;
      halted_q   <= halted_d;
      cyc_q      <= cyc_d;
      rep_q      <= rep_d;
      pc_prev_q  <= pc_prev_d;
      prev_vld_q <= prev_vld_d;
`ifdef MCCOY_FEEDER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.load_ready  = (state_q == S_LOAD);
  assign bus.core_reset  = !running;
  assign bus.instr_out   = (running && pc_hit) ? rdata : FILL_WORD;
  assign bus.halted      = halted_q;
  assign bus.cycle_count = cyc_q;
`ifdef MCCOY_FEEDER_CSUM_EN
  assign bus.csum        = csum_q;
`endif
endmodule

// File: doc/mccoy_prog_feeder.md
Name: mccoy_prog_feeder

Overview:
Instruction-supply stage directly upstream of the McCoy core.
- Holds a 64x6 program memory, loaded through a valid/ready byte stream.
- Holds the core in reset until a run is requested, then returns the word at the core's current PC every cycle.
- Detects the self-loop halt idiom and counts executed cycles, so a harness or tester can run whole programs unattended.

Parameters:
- DEPTH, 64: program words; equals the 6-bit PC range. Must be a power of two ≤ 64.
- IW, 6: instruction width; opcode in [2:0], reg/imm in [5:3].
- FILL_WORD, 6'b000000: word returned for any PC at or beyond the loaded length.
- HALT_REPEAT, 4: consecutive cycles of an unchanged pc_in that declare a halt. Legal range 2..15.
- CW, 16: cycle counter width.

Ports:
- clk, in, 1: single clock; the same clock the core uses.
- reset, in, 1: asynchronous, active-low reset.
- load_start, in, 1: pulse in IDLE to begin a program load.
- load_valid, in, 1: load_data is valid.
- load_last, in, 1: qualifies the final word of the load.
- load_data, in, IW: instruction word.
- load_ready, out, 1: feeder accepts a word this cycle.
- run_en, in, 1: level. High starts or keeps a run; low aborts.
- pc_in, in, 6: core PC, demuxed from the high phase of io_out.
- instr_out, out, IW: drives the core's instr (io_in[7:2]).
- core_reset, out, 1: active-high reset to the core (io_in[1]).
- halted, out, 1: halt detected.
- cycle_count, out, CW: RUN cycles executed.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wr_ptr=0, len=0, loaded=0.
  - core_reset=1, load_ready=0, halted=0, cycle_count=0.
  - Memory contents are not cleared.
- States: IDLE, LOAD, PRIME, RUN, HALT.
- IDLE:
  - core_reset=1; instr_out=FILL_WORD.
  - load_start has priority over run_en: it moves to LOAD with wr_ptr=0 and loaded=0.
  - If loaded=1 and run_en=1, move to PRIME.
- LOAD:
  - load_ready=1.
  - On load_valid&load_ready: write mem[wr_ptr] and increment wr_ptr.
  - If load_last or wr_ptr==DEPTH-1: len=wr_ptr+1 (range 1..DEPTH, stored in 7 bits), loaded=1, go to IDLE.
  - Words offered after the DEPTH-th are never accepted.
  - load_start and run_en are ignored in LOAD.
- PRIME:
  - Lasts exactly one cycle. core_reset=1, cycle_count cleared, halted cleared, the halt repeat counter cleared.
  - Then RUN.
- RUN:
  - core_reset=0.
  - instr_out is combinational: mem[pc_in] if pc_in<len, else FILL_WORD. There is zero latency, so the word is stable before the core's next posedge.
  - cycle_count increments each cycle and saturates at all-ones.
  - Repeat counter: it increments when pc_in equals the value registered last cycle and clears otherwise.
  - When the repeat counter reaches HALT_REPEAT-1, go to HALT with halted=1.
  - run_en=0 goes to IDLE (abort), core_reset=1 next cycle, and cycle_count is retained.
- HALT:
  - core_reset=0; instr_out keeps tracking pc_in; cycle_count frozen; halted=1.
  - run_en=0 goes to IDLE with halted retained.
  - run_en held high stays in HALT.
- Simultaneous events:
  - Reset mid-LOAD discards the partial load (loaded=0).
  - Abort followed by run_en=1 re-enters through PRIME and restarts from PC 0.

Optional Feature:
- Macro: MCCOY_FEEDER_CSUM_EN.
- Defined:
  - Adds output csum[IW-1:0]: XOR of all accepted load words.
  - Cleared on load_start and on reset; valid when loaded=1.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package mccoy_feeder_pkg holds:
  - state enum (IDLE, LOAD, PRIME, RUN, HALT);
  - PC_W=6, IW=6;
  - FILL_WORD default.
- Sub-module mccoy_prog_mem:
  - DEPTH x IW array with synchronous write and asynchronous read.
  - No reset on the array.

Test Plan:
- Load 5 words 0x01..0x05 with load_last on the 5th, then run_en=1 → exactly one PRIME cycle with core_reset=1; pc_in=2 → instr_out=0x03; pc_in=7 → FILL_WORD.
- Stream 70 words without load_last → the 64th write ends the load, load_ready=0 afterwards, len=64, and all 64 read back correctly in RUN.
- RUN with pc_in sequence 0,1,2,3,3,3,3 → halted=1 on the 4th consecutive 3, and cycle_count=7 and frozen from then on.
- Deassert run_en mid-RUN → IDLE with core_reset=1 next cycle; reassert → PRIME, cycle_count restarts from 0.
- Assert reset low during LOAD after 3 words → IDLE immediately, loaded=0, and run_en=1 has no effect until a new load completes.
- With MCCOY_FEEDER_CSUM_EN defined, load 0x15,0x2A,0x3F → csum=0x00; load 0x01 alone → csum=0x01.
